rr_arbiter_ctrl: RTL and testbench
==================================

RR_ARBITER_CTRL -- requirements
Module: rr_arbiter_ctrl

Interface
REQ-001 SHALL have parameter W_DATA, default 8: number of requesters (2..64, any integer, not only powers of 2).
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles a grant may be held when RR_TIMEOUT_EN is defined (1..255).
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port req  in  W_DATA: request vector; bit i high means requester i wants the resource.
REQ-006 SHALL have port release  in  1: one-cycle pulse from the current grant holder ending its tenure.
REQ-007 SHALL have port gnt  out  W_DATA: registered one-hot grant vector, all-zero when nothing is granted.
REQ-008 SHALL have port gnt_valid  out  1: high exactly when gnt is non-zero.
REQ-009 SHALL have port gnt_idx  out  $clog2(W_DATA): binary index of the granted requester, 0 when gnt_valid is low.
REQ-010 SHALL have port shift_value  out  $clog2(W_DATA): current priority pointer, fed to the downstream counter-clockwise rotation ring.
REQ-011 SHALL have port timeout_err  out  1: one-cycle pulse on a forced release.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-013 In IDLE with req == 0, SHALL stay in IDLE with all outputs unchanged.
REQ-014 In IDLE with req != 0, SHALL select the first set bit at cyclic index ptr, ptr+1, ..., W_DATA-1, 0, ..., ptr-1. It SHALL register gnt, gnt_idx and gnt_valid at that edge and move to GRANT. The grant is visible in the cycle after req was sampled, giving one-cycle latency.
REQ-015 In GRANT, gnt, gnt_idx and gnt_valid SHALL hold constant regardless of req changes, including the holder dropping its req, until a release or forced release occurs.
REQ-016 In GRANT with release high, SHALL clear gnt, gnt_idx and gnt_valid, set ptr to (gnt_idx+1) mod W_DATA, and return to IDLE at that edge.
REQ-017 Pointer wrap: a holder at index W_DATA-1 SHALL set ptr to 0. Non-power-of-2 W_DATA SHALL never produce ptr >= W_DATA.
REQ-018 release in IDLE SHALL be ignored, with no pointer change.
REQ-019 release and new req in the same GRANT cycle: release SHALL take effect first. Arbitration SHALL occur in the following IDLE cycle using the updated ptr. The minimum gap between grants is one IDLE cycle.
REQ-020 shift_value SHALL equal ptr at all times and change only on the release edge or the forced-release edge.
REQ-021 Only one gnt bit SHALL ever be high, and gnt SHALL never be granted to a requester whose req was low at the arbitration edge.
REQ-022 Fairness: with all req bits continuously high, grants SHALL visit indices in strictly increasing cyclic order.

Reset
REQ-023 rst high SHALL asynchronously force state IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout_err=0 and hold timeout counter=0.
REQ-024 rst asserted during GRANT SHALL drop the grant immediately without a timeout_err pulse. The first arbitration after deassertion SHALL start from ptr=0.

Configuration
REQ-025 Macro RR_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on entry to GRANT and increment each GRANT cycle without release. When it reaches TIMEOUT-1 with no release, the next edge SHALL force a release per REQ-016 and pulse timeout_err high for one cycle.
REQ-026 Macro RR_TIMEOUT_EN undefined: no counter SHALL be synthesised, grants SHALL be held indefinitely until release, and timeout_err SHALL be tied 0.

Verification
REQ-027 Reset, then req=8'b0000_0100 -> next cycle gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1; after release, shift_value=3.
REQ-028 ptr=0, req=8'hFF held, release pulsed each GRANT cycle -> gnt_idx sequence 0,1,2,...,7,0 with one IDLE cycle between grants.
REQ-029 ptr=5, req=8'b0001_0001 -> gnt_idx=0 after the wrap; after release, shift_value=1.
REQ-030 Grant to idx 3, then req drops to 0 and rises again without release -> gnt stays 8'b0000_1000 unchanged. With RR_TIMEOUT_EN and TIMEOUT=16, gnt clears 16 cycles after the grant, timeout_err pulses once and shift_value=4.
REQ-031 rst pulsed mid-GRANT at idx 6 -> gnt=0 immediately (asynchronous); then req=8'hC0 -> gnt_idx=6 with ptr=0.
REQ-032 W_DATA=5, holder idx 4 released -> shift_value=0, never 5..7.

Source files
------------

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter with held grants, released by a one-cycle pulse on release_i.
// `release` is a reserved word, so that input is named release_i. Define RR_TIMEOUT_EN to add a forced-release hold counter.
module rr_arbiter_ctrl #(
    parameter int W_DATA  = 8,
    parameter int TIMEOUT = 16,
    localparam int IW     = (W_DATA > 1) ? $clog2(W_DATA) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] req,
    input  logic              release_i,
    output logic [W_DATA-1:0] gnt,
    output logic              gnt_valid,
    output logic [IW-1:0]     gnt_idx,
    output logic [IW-1:0]     shift_value,
    output logic              timeout_err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [W_DATA-1:0] gnt_q, gnt_d;
    logic [IW-1:0]     gnt_idx_q, gnt_idx_d;

    logic              found;
    logic [IW-1:0]     sel_idx;
    logic [W_DATA-1:0] sel_oh;
    logic [IW-1:0]     next_ptr;
    logic              timeout_hit;
    logic              end_grant;

    // Two passes give the cyclic search order: bits at or above ptr first, then the wrap-around.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        for (int j = 0; j < W_DATA; j++) begin
            if (!found && req[j] && (IW'(j) >= ptr_q)) begin
                found     = 1'b1;
                sel_idx   = IW'(j);
                sel_oh[j] = 1'b1;
            end
        end
        for (int j = 0; j < W_DATA; j++) begin
            if (!found && req[j]) begin
                found     = 1'b1;
                sel_idx   = IW'(j);
                sel_oh[j] = 1'b1;
            end
        end
    end

    assign next_ptr  = (gnt_idx_q == IW'(W_DATA - 1)) ? '0 : gnt_idx_q + IW'(1);
    assign end_grant = release_i | timeout_hit;

`ifdef RR_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       terr_q, terr_d;

    assign timeout_hit = (state_q == GRANT) && (cnt_q == 8'(TIMEOUT - 1));

    // Counter sits at zero in IDLE, so every GRANT tenure starts counting from zero.
    always_comb begin
        cnt_d  = cnt_q;
        terr_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!release_i) begin
            cnt_d  = cnt_q + 8'd1;
            terr_d = timeout_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = GRANT;
                    gnt_d     = sel_oh;
                    gnt_idx_d = sel_idx;
                end
            end
            default: begin
                if (end_grant) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    ptr_d     = next_ptr;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_valid   = (state_q == GRANT);
    assign gnt_idx     = gnt_idx_q;
    assign shift_value = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Bench for rr_arbiter_ctrl: 8-requester instance with a grant scoreboard, plus a 5-requester instance for pointer wrap.
module tb_rr_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       release_i;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [2:0] shift_value;
    logic       timeout_err;

    logic [4:0] req5;
    logic       rel5;
    logic [4:0] gnt5;
    logic       gnt_valid5;
    logic [2:0] gnt_idx5;
    logic [2:0] shift5;
    logic       terr5;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] exp_q[$];
    logic [2:0] model_ptr;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_ctrl #(.W_DATA(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .release_i(release_i),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
        .shift_value(shift_value), .timeout_err(timeout_err)
    );

    rr_arbiter_ctrl #(.W_DATA(5), .TIMEOUT(16)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .release_i(rel5),
        .gnt(gnt5), .gnt_valid(gnt_valid5), .gnt_idx(gnt_idx5),
        .shift_value(shift5), .timeout_err(terr5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] c;
        for (int i = 0; i < 8; i++) begin
            c = p + 3'(i);
            if (r[c]) return c;
        end
        return 3'd0;
    endfunction

    // Scoreboard: every rising grant must match the oldest expected index.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (gnt_valid && !prev_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: got gnt_idx %0d with nothing expected", gnt_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (gnt_idx !== e) begin
                        tests_failed++;
                        $display("FAIL sb_idx: got %0d expected %0d", gnt_idx, e);
                    end
                end
            end
            prev_valid = gnt_valid;
        end
    end

    task automatic grant_cycle(input logic [7:0] r, input int hold);
        logic [2:0] e;
        logic [7:0] oh;
        e  = pick(r, model_ptr);
        oh = 8'(1) << e;
        exp_q.push_back(e);
        req = r;
        tick();
        tests_run++;
        if (gnt_valid !== 1'b1 || gnt !== oh || gnt_idx !== e) begin
            tests_failed++;
            $display("FAIL grant_latency: got gnt %0h idx %0d v %0b expected gnt %0h idx %0d", gnt, gnt_idx, gnt_valid, oh, e);
        end
        for (int h = 0; h < hold; h++) begin
            req = 8'($urandom_range(0, 255));
            tick();
            tests_run++;
            if (gnt !== oh || gnt_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL grant_hold: got gnt %0h expected %0h", gnt, oh);
            end
        end
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        model_ptr = e + 3'd1;
        tests_run++;
        if (gnt_valid !== 1'b0 || gnt !== 8'h00 || gnt_idx !== 3'd0 || shift_value !== model_ptr) begin
            tests_failed++;
            $display("FAIL release: got gnt %0h v %0b shift %0d expected gnt 0 shift %0d", gnt, gnt_valid, shift_value, model_ptr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        release_i = 1'b0;
        tick();
        rst = 1'b0;
        model_ptr = 3'd0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || shift_value !== 3'd0 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got gnt %0h v %0b idx %0d shift %0d terr %0b expected all 0", gnt, gnt_valid, gnt_idx, shift_value, timeout_err);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(3'd2);
        req = 8'b0000_0100;
        tick();
        tests_run++;
        if (gnt !== 8'b0000_0100 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_grant: got gnt %0h idx %0d v %0b expected 04 2 1", gnt, gnt_idx, gnt_valid);
        end
        req = 8'h00;
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        tests_run++;
        if (shift_value !== 3'd3 || gnt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_shift: got shift %0d v %0b expected 3 0", shift_value, gnt_valid);
        end
        model_ptr = 3'd3;
    endtask

    task automatic test_release_idle();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        tick();
        tests_run++;
        if (shift_value !== model_ptr || gnt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_idle: got shift %0d v %0b expected %0d 0", shift_value, gnt_valid, model_ptr);
        end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 9; i++) begin
            grant_cycle(8'hFF, 0);
            tests_run++;
            if (shift_value !== 3'((i + 1) % 8)) begin
                tests_failed++;
                $display("FAIL fairness_order: step %0d got ptr %0d expected %0d", i, shift_value, (i + 1) % 8);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_wrap();
        grant_cycle(8'b0001_0000, 0);
        grant_cycle(8'b0001_0001, 1);
        tests_run++;
        if (shift_value !== 3'd1) begin
            tests_failed++;
            $display("FAIL wrap_shift: got %0d expected 1", shift_value);
        end
        req = 8'h00;
    endtask

    task automatic test_hold();
        int  drop_at;
        logic bad;
        exp_q.push_back(3'd3);
        req = 8'b0000_1000;
        tick();
        tests_run++;
        if (gnt !== 8'b0000_1000 || gnt_idx !== 3'd3) begin
            tests_failed++;
            $display("FAIL hold_grant: got gnt %0h idx %0d expected 08 3", gnt, gnt_idx);
        end
        drop_at = 0;
        bad     = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            req = (k >= 5 && k < 10) ? 8'hFF : 8'h00;
            tick();
            if (gnt_valid !== 1'b1 && drop_at == 0) drop_at = k;
            if (drop_at == 0 && (gnt !== 8'b0000_1000 || timeout_err !== 1'b0)) bad = 1'b1;
            if (drop_at == k) begin
                tests_run++;
                if (timeout_err !== 1'b1 || shift_value !== 3'd4) begin
                    tests_failed++;
                    $display("FAIL timeout_pulse: got terr %0b shift %0d expected 1 4", timeout_err, shift_value);
                end
            end
            if (drop_at != 0 && drop_at != k && timeout_err !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL hold_stable: got grant change or stray timeout_err, expected 08 held");
        end
`ifdef RR_TIMEOUT_EN
        tests_run++;
        if (drop_at != 16) begin
            tests_failed++;
            $display("FAIL timeout_cycles: got %0d expected 16", drop_at);
        end
`else
        tests_run++;
        if (drop_at != 0) begin
            tests_failed++;
            $display("FAIL hold_forever: got drop at %0d expected none", drop_at);
        end
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
`endif
        model_ptr = 3'd4;
        tests_run++;
        if (shift_value !== 3'd4 || gnt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_shift: got shift %0d v %0b expected 4 0", shift_value, gnt_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            grant_cycle(8'($urandom_range(1, 255)), $urandom_range(0, 3));
        end
        req = 8'h00;
    endtask

    task automatic test_reset_mid_grant();
        exp_q.push_back(3'd6);
        req = 8'h40;
        tick();
        tests_run++;
        if (gnt !== 8'h40) begin
            tests_failed++;
            $display("FAIL pre_reset_grant: got %0h expected 40", gnt);
        end
        req = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || shift_value !== 3'd0 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got gnt %0h v %0b shift %0d terr %0b expected 0", gnt, gnt_valid, shift_value, timeout_err);
        end
        tick();
        rst = 1'b0;
        model_ptr = 3'd0;
        grant_cycle(8'hC0, 0);
        req = 8'h00;
    endtask

    task automatic test_w5();
        req5 = 5'b1_0000;
        tick();
        tests_run++;
        if (gnt5 !== 5'b1_0000 || gnt_idx5 !== 3'd4) begin
            tests_failed++;
            $display("FAIL w5_grant: got gnt %0h idx %0d expected 10 4", gnt5, gnt_idx5);
        end
        req5 = 5'b0;
        rel5 = 1'b1;
        tick();
        rel5 = 1'b0;
        tests_run++;
        if (shift5 !== 3'd0) begin
            tests_failed++;
            $display("FAIL w5_wrap: got shift %0d expected 0", shift5);
        end
        req5 = 5'b1_1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (gnt_idx5 !== 3'(i % 5) || gnt_valid5 !== 1'b1) begin
                tests_failed++;
                $display("FAIL w5_order: step %0d got idx %0d expected %0d", i, gnt_idx5, i % 5);
            end
            rel5 = 1'b1;
            tick();
            rel5 = 1'b0;
            tests_run++;
            if (shift5 !== 3'((i + 1) % 5)) begin
                tests_failed++;
                $display("FAIL w5_ptr: step %0d got %0d expected %0d", i, shift5, (i + 1) % 5);
            end
        end
        req5 = 5'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 8'h00;
        release_i = 1'b0;
        req5      = 5'b0;
        rel5      = 1'b0;
        model_ptr = 3'd0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_release_idle();
        do_reset();
        test_fairness();
        test_wrap();
        test_hold();
        test_back_to_back();
        test_reset_mid_grant();
        test_w5();
        tick();
        tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got %0d pending grants expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
